// File: rtl/fcc_way_arbiter.sv
// Per-way command gate with round-robin NAND bus arbitration, keep_wait generation and PHY pin mux.
// Optional LOCK watchdog enabled by defining FCC_ARB_WATCHDOG_EN.
module fcc_way_arbiter #(
  parameter int unsigned CH_NUM       = 4,
  parameter int unsigned LOCK_TIMEOUT = 1023
) (
  input  logic                  usr_clk,
  input  logic                  usr_rst,
  input  logic [CH_NUM-1:0]     i_sched_valid,
  output logic [CH_NUM-1:0]     o_sched_ready,
  output logic [CH_NUM-1:0]     o_exec_valid,
  input  logic [CH_NUM-1:0]     i_exec_ready,
  input  logic [2*CH_NUM-1:0]   i_exec_status,
  output logic [CH_NUM-1:0]     o_keep_wait,
  input  logic [CH_NUM-1:0]     i_io_busy,
  input  logic [CH_NUM-1:0]     i_ce_n,
  input  logic [CH_NUM-1:0]     i_we_n,
  input  logic [CH_NUM-1:0]     i_cle,
  input  logic [CH_NUM-1:0]     i_ale,
  input  logic [CH_NUM-1:0]     i_wp_n,
  input  logic [CH_NUM-1:0]     i_dqs_tri_en,
  input  logic [CH_NUM-1:0]     i_dq_tri_en,
  input  logic [4*CH_NUM-1:0]   i_re,
  input  logic [4*CH_NUM-1:0]   i_dqs,
  input  logic [32*CH_NUM-1:0]  i_dq,
  output logic [CH_NUM-1:0]     o_ce_n,
  output logic                  o_we_n,
  output logic                  o_cle,
  output logic                  o_ale,
  output logic                  o_wp_n,
  output logic                  o_dqs_tri_en,
  output logic                  o_dq_tri_en,
  output logic [3:0]            o_re,
  output logic [3:0]            o_dqs,
  output logic [31:0]           o_dq,
  output logic                  o_bus_conflict,
  output logic [CH_NUM-1:0]     o_timeout
);

  localparam int unsigned GW = (CH_NUM > 1) ? $clog2(CH_NUM) : 1;

  typedef enum logic [1:0] {StIdle, StWait, StLock, StFin} state_e;

  state_e            state_q [CH_NUM];
  state_e            state_d [CH_NUM];
  logic [CH_NUM-1:0] exec_valid_q, exec_valid_d;
  logic [CH_NUM-1:0] keep_wait_d;
  logic [GW-1:0]     last_grant_q, last_grant_d;
  logic [GW-1:0]     owner_q, owner_d;
  logic [GW-1:0]     grant_idx;
  logic              grant_vld;
  logic              any_lock;
  int unsigned       rr_idx;

`ifdef FCC_ARB_WATCHDOG_EN
  localparam int unsigned CntW = $clog2(LOCK_TIMEOUT + 1);
  logic [CntW-1:0]   lock_cnt_q [CH_NUM];
  logic [CntW-1:0]   lock_cnt_d [CH_NUM];
  logic [CH_NUM-1:0] timeout_q, timeout_d;
  assign o_timeout = timeout_q;
`else
  logic unused_lock_timeout;
  assign unused_lock_timeout = ^LOCK_TIMEOUT;
  assign o_timeout = '0;
`endif

  assign o_exec_valid = exec_valid_q;

  // Grants are withheld while any channel holds the bus command path.
  always_comb begin
    any_lock  = 1'b0;
    grant_vld = 1'b0;
    grant_idx = '0;
    rr_idx    = 0;
    for (int k = 0; k < CH_NUM; k++) begin
      if (state_q[k] == StLock) any_lock = 1'b1;
    end
    for (int i = 1; i <= CH_NUM; i++) begin
      rr_idx = (int'(last_grant_q) + i) % CH_NUM;
      if (!grant_vld && !any_lock && state_q[rr_idx] == StWait) begin
        grant_vld = 1'b1;
        grant_idx = GW'(rr_idx);
      end
    end
  end

  always_comb begin
    exec_valid_d = exec_valid_q;
    last_grant_d = grant_vld ? grant_idx : last_grant_q;
`ifdef FCC_ARB_WATCHDOG_EN
    timeout_d = timeout_q;
`endif
    for (int k = 0; k < CH_NUM; k++) begin
      state_d[k] = state_q[k];
`ifdef FCC_ARB_WATCHDOG_EN
      lock_cnt_d[k] = lock_cnt_q[k];
`endif
      case (state_q[k])
        StIdle: if (i_sched_valid[k]) state_d[k] = StWait;
        StWait: begin
          if (grant_vld && grant_idx == GW'(k)) begin
            state_d[k]      = StLock;
            exec_valid_d[k] = 1'b1;
`ifdef FCC_ARB_WATCHDOG_EN
            lock_cnt_d[k]   = '0;
`endif
          end
        end
        StLock: begin
`ifdef FCC_ARB_WATCHDOG_EN
          lock_cnt_d[k] = lock_cnt_q[k] + 1'b1;
`endif
          if (!i_exec_ready[k]) begin
            state_d[k]      = StFin;
            exec_valid_d[k] = 1'b0;
          end
`ifdef FCC_ARB_WATCHDOG_EN
          // Counter reaches LOCK_TIMEOUT on this edge: abandon and re-arbitrate.
          else if (lock_cnt_q[k] == CntW'(LOCK_TIMEOUT - 1)) begin
            state_d[k]      = StWait;
            exec_valid_d[k] = 1'b0;
            timeout_d[k]    = 1'b1;
          end
`endif
        end
        StFin:   if (i_exec_ready[k]) state_d[k] = StIdle;
        default: state_d[k] = StIdle;
      endcase
    end
  end

  always_comb begin
    keep_wait_d = '0;
    for (int k = 0; k < CH_NUM; k++) begin
      for (int j = 0; j < CH_NUM; j++) begin
        if (j != k && i_exec_status[2*j +: 2] == 2'h1) keep_wait_d[k] = 1'b1;
      end
    end
  end

  // Lowest busy channel owns the pins; with none busy the last owner is kept.
  always_comb begin
    owner_d = owner_q;
    for (int k = CH_NUM - 1; k >= 0; k--) begin
      if (i_io_busy[k]) owner_d = GW'(k);
    end
  end

  always_ff @(posedge usr_clk) begin
    if (usr_rst) begin
      for (int k = 0; k < CH_NUM; k++) state_q[k] <= StIdle;
      exec_valid_q   <= '0;
      last_grant_q   <= GW'(CH_NUM - 1);
      owner_q        <= '0;
      o_sched_ready  <= '0;
      o_keep_wait    <= '0;
      o_bus_conflict <= 1'b0;
      o_ce_n         <= '1;
      o_we_n         <= 1'b1;
      o_cle          <= 1'b0;
      o_ale          <= 1'b0;
      o_wp_n         <= 1'b1;
      o_re           <= 4'hf;
      o_dqs_tri_en   <= 1'b0;
      o_dqs          <= 4'hf;
      o_dq_tri_en    <= 1'b1;
      o_dq           <= '0;
    end else begin
      for (int k = 0; k < CH_NUM; k++) begin
        state_q[k]       <= state_d[k];
        o_sched_ready[k] <= (state_q[k] == StIdle) && !i_sched_valid[k];
      end
      exec_valid_q   <= exec_valid_d;
      last_grant_q   <= last_grant_d;
      owner_q        <= owner_d;
      o_keep_wait    <= keep_wait_d;
      o_bus_conflict <= o_bus_conflict | ((i_io_busy & (i_io_busy - 1'b1)) != '0);
      o_ce_n         <= i_ce_n;
      o_we_n         <= i_we_n[owner_d];
      o_cle          <= i_cle[owner_d];
      o_ale          <= i_ale[owner_d];
      o_wp_n         <= i_wp_n[owner_d];
      o_re           <= i_re[4*owner_d +: 4];
      o_dqs_tri_en   <= i_dqs_tri_en[owner_d];
      o_dqs          <= i_dqs[4*owner_d +: 4];
      o_dq_tri_en    <= i_dq_tri_en[owner_d];
      o_dq           <= i_dq[32*owner_d +: 32];
    end
  end

`ifdef FCC_ARB_WATCHDOG_EN
  always_ff @(posedge usr_clk) begin
    if (usr_rst) begin
      for (int k = 0; k < CH_NUM; k++) lock_cnt_q[k] <= '0;
      timeout_q <= '0;
    end else begin
      for (int k = 0; k < CH_NUM; k++) lock_cnt_q[k] <= lock_cnt_d[k];
      timeout_q <= timeout_d;
    end
  end
`endif

endmodule
